filter_sequencer: RTL and testbench

FILTER_SEQUENCER -- requirements
Module: filter_sequencer

---
 rtl/filter_sequencer_pkg.sv | 33 +++
 rtl/filter_seq_cfg_rom.sv | 29 ++
 rtl/filter_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_filter_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_sequencer_pkg.sv
// Shared definitions for filter_sequencer: FSM encoding, host register map
// and stream_filter configuration addresses.
package filter_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG_W  = 3'd1,
        S_CFG_K  = 3'd2,
        S_CFG_R  = 3'd3,
        S_STREAM = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [3:0] HOST_WIDTH    = 4'd0;
    localparam logic [3:0] HOST_HEIGHT   = 4'd1;
    localparam logic [3:0] HOST_RESCALE  = 4'd2;
    localparam logic [3:0] HOST_K0       = 4'd3;
    localparam logic [3:0] HOST_K8       = 4'd11;
    localparam logic [3:0] HOST_EXPECTED = 4'd12;

    localparam logic [1:0] CFG_WIDTH   = 2'd1;
    localparam logic [1:0] CFG_KERNEL  = 2'd2;
    localparam logic [1:0] CFG_RESCALE = 2'd3;

    // Step index of the cfg burst: 0 width, 1..9 kernel taps, 10 rescale.
    localparam logic [3:0] STEP_W      = 4'd0;
    localparam logic [3:0] STEP_K_LAST = 4'd9;
    localparam logic [3:0] STEP_R      = 4'd10;

    typedef logic [8:0][15:0] kernel_t;

endpackage

// File: rtl/filter_seq_cfg_rom.sv
// Maps a cfg burst step index (0..10) onto the stream_filter address/data pair
// taken from the sequencer's shadow registers.
module filter_seq_cfg_rom
    import filter_sequencer_pkg::*;
(
    input  logic [3:0]  step,
    input  logic [15:0] width,
    input  logic [15:0] rescale,
    input  kernel_t     kernel,
    output logic [1:0]  addr,
    output logic [31:0] data
);

    always_comb begin
        addr = 2'd0;
        data = 32'd0;
        if (step == STEP_W) begin
            addr = CFG_WIDTH;
            data = {16'd0, width};
        end else if (step <= STEP_K_LAST) begin
            addr = CFG_KERNEL;
            data = {16'd0, kernel[step - 4'd1]};
        end else if (step == STEP_R) begin
            addr = CFG_RESCALE;
            data = {16'd0, rescale};
        end
    end

endmodule

// File: rtl/filter_sequencer.sv
// Frame sequencer for stream_filter: cfg burst, gated pixel stream, result drain.
// Optional drain watchdog enabled by defining FILTER_SEQ_WATCHDOG_EN.
module filter_sequencer
    import filter_sequencer_pkg::*;
#(
    parameter int CFG_DWIDTH  = 32,
    parameter int CFG_AWIDTH  = 5,
    parameter int IMG_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           host_data,
    input  logic [3:0]            host_addr,
    input  logic                  host_valid,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CFG_DWIDTH-1:0] cfg_data,
    output logic [CFG_AWIDTH-1:0] cfg_addr,
    output logic                  cfg_valid,
    input  logic [IMG_WIDTH-1:0]  in_image,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [IMG_WIDTH-1:0]  image,
    output logic                  image_val,
    input  logic                  result_val
);

    if (WDOG_CYCLES < 2) begin : g_wdog_param_check
        $error("WDOG_CYCLES must be at least 2");
    end

    state_t               state, state_nxt;
    logic [15:0]          width_r, height_r, rescale_r;
    kernel_t              kernel_r;
    logic [CNT_WIDTH-1:0] expected_r, pix_cnt, res_cnt, res_cnt_nxt;
    logic [31:0]          frame_size;
    logic [3:0]           step;
    logic [1:0]           rom_addr;
    logic [31:0]          rom_data;
    logic                 accept, last_pix, res_inc, drain_ok, wdog_timeout;

    filter_seq_cfg_rom u_cfg_rom (
        .step    (step),
        .width   (width_r),
        .rescale (rescale_r),
        .kernel  (kernel_r),
        .addr    (rom_addr),
        .data    (rom_data)
    );

    // in_rdy is a pure decode of STREAM, so accept is derived from state directly.
    assign accept      = in_val && (state == S_STREAM);
    assign last_pix    = accept && ((pix_cnt + CNT_WIDTH'(1)) == CNT_WIDTH'(frame_size));
    assign res_inc     = result_val && (state == S_STREAM || state == S_DRAIN);
    assign res_cnt_nxt = res_cnt + CNT_WIDTH'(res_inc);
    // A result arriving on the deciding cycle still counts toward completion.
    assign drain_ok    = (res_cnt == expected_r) || (res_cnt_nxt == expected_r);

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        cfg_valid = 1'b0;
        in_rdy    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_CFG_W;
            end
            S_CFG_W: begin
                cfg_valid = 1'b1;
                state_nxt = S_CFG_K;
            end
            S_CFG_K: begin
                cfg_valid = 1'b1;
                if (step == STEP_K_LAST) state_nxt = S_CFG_R;
            end
            S_CFG_R: begin
                cfg_valid = 1'b1;
                state_nxt = (frame_size == 32'd0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                in_rdy = 1'b1;
                if (last_pix) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_ok || wdog_timeout) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (cfg_valid) begin
            cfg_addr = CFG_AWIDTH'(rom_addr);
            cfg_data = CFG_DWIDTH'(rom_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            step       <= 4'd0;
            width_r    <= 16'd0;
            height_r   <= 16'd0;
            rescale_r  <= 16'd0;
            kernel_r   <= '0;
            expected_r <= '0;
            frame_size <= 32'd0;
            pix_cnt    <= '0;
            res_cnt    <= '0;
            image      <= '0;
            image_val  <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= cfg_valid ? step + 4'd1 : 4'd0;
            image_val <= accept;
            res_cnt   <= res_cnt_nxt;
            if (accept) begin
                image   <= in_image;
                pix_cnt <= pix_cnt + CNT_WIDTH'(1);
            end
            if (state == S_IDLE && host_valid) begin
                case (host_addr)
                    HOST_WIDTH:    width_r    <= host_data[15:0];
                    HOST_HEIGHT:   height_r   <= host_data[15:0];
                    HOST_RESCALE:  rescale_r  <= host_data[15:0];
                    HOST_EXPECTED: expected_r <= CNT_WIDTH'(host_data);
                    default: begin
                        if (host_addr >= HOST_K0 && host_addr <= HOST_K8)
                            kernel_r[host_addr - HOST_K0] <= host_data[15:0];
                    end
                endcase
            end
            if (state == S_IDLE && start)
                frame_size <= 32'(width_r) * 32'(height_r);
            if (state == S_DONE) begin
                pix_cnt <= '0;
                res_cnt <= '0;
            end
        end
    end

`ifdef FILTER_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);

    logic [WDW-1:0] wdog_cnt;
    logic           err_r;

    // Counts DRAIN cycles since the last result; fires one cycle early so DONE
    // lands exactly WDOG_CYCLES after that result.
    assign wdog_timeout = (state == S_DRAIN) && !result_val &&
                          (wdog_cnt == WDW'(WDOG_CYCLES - 1));
    assign err = err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            err_r    <= 1'b0;
        end else begin
            if (state == S_DRAIN)
                wdog_cnt <= result_val ? WDW'(1) : wdog_cnt + WDW'(1);
            else
                wdog_cnt <= '0;
            if (state == S_IDLE && start)
                err_r <= 1'b0;
            else if (wdog_timeout && !drain_ok)
                err_r <= 1'b1;
        end
    end
`else
    assign wdog_timeout = 1'b0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_filter_sequencer.sv
// Randomized self-checking bench for filter_sequencer against a frame-timeline model.
// Define FILTER_SEQ_WATCHDOG_EN to also exercise the drain watchdog.
module tb_filter_sequencer;

    localparam int WDOG = 16;
    localparam int BIG  = 1000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] host_data = '0;
    logic [3:0]  host_addr = '0;
    logic        host_valid = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic [15:0] in_image = '0;
    logic        in_val = 1'b0;
    logic        in_rdy;
    logic [15:0] image;
    logic        image_val;
    logic        result_val = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // Reference shadow registers as the host believes them to be.
    logic [15:0] m_w, m_h, m_resc;
    logic [15:0] m_k [9];
    logic [31:0] m_exp;

    filter_sequencer #(
        .CFG_DWIDTH (32),
        .CFG_AWIDTH (5),
        .IMG_WIDTH  (16),
        .CNT_WIDTH  (32),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host_data  (host_data),
        .host_addr  (host_addr),
        .host_valid (host_valid),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cfg_data   (cfg_data),
        .cfg_addr   (cfg_addr),
        .cfg_valid  (cfg_valid),
        .in_image   (in_image),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .image      (image),
        .image_val  (image_val),
        .result_val (result_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        m_w = '0; m_h = '0; m_resc = '0; m_exp = '0;
        for (int i = 0; i < 9; i++) m_k[i] = '0;
    endtask

    // Called only while idle, so the model always takes the write.
    task automatic host_wr(input logic [3:0] a, input logic [31:0] d);
        host_valid = 1'b1; host_addr = a; host_data = d;
        @(posedge clk); #1;
        host_valid = 1'b0; host_addr = '0; host_data = '0;
        if (a == 4'd0) m_w = d[15:0];
        else if (a == 4'd1) m_h = d[15:0];
        else if (a == 4'd2) m_resc = d[15:0];
        else if (a >= 4'd3 && a <= 4'd11) m_k[a - 4'd3] = d[15:0];
        else if (a == 4'd12) m_exp = d;
    endtask

    task automatic chk_quiet_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
        chk({tag, "_outs"}, 64'({done, err, in_rdy, image_val, cfg_addr, cfg_data, image}), 64'd0);
    endtask

    // Cycle 0 = start high; 1..11 cfg burst; stream from 12 until frame_size pixels
    // are taken; drain from the next cycle; done follows the timeline rules below.
    task automatic run_frame(input string tag, input int val_pct, input int res_pct,
                             input int n_res, input bit early, input bit busy_wr);
        logic [31:0] fs;
        logic [31:0] exp_d [11];
        logic [4:0]  exp_a [11];
        logic [15:0] prev_pix;
        int acc, D, R, last_dr, done_k, seen_k, nres, quota;
        int cfg_err, busy_err, rdy_err, img_err, iv_cnt, done_cnt;
        bit prev_acc, err_exp, err_seen, rdy_exp;

        exp_a[0] = 5'd1; exp_d[0] = {16'd0, m_w};
        for (int i = 0; i < 9; i++) begin
            exp_a[i+1] = 5'd2; exp_d[i+1] = {16'd0, m_k[i]};
        end
        exp_a[10] = 5'd3; exp_d[10] = {16'd0, m_resc};
        fs = 32'(m_w) * 32'(m_h);
        acc = 0; D = -1; R = (m_exp == 0) ? 0 : -1; last_dr = -1;
        done_k = (fs == 0) ? 12 : BIG; seen_k = -1; nres = 0; quota = n_res;
        cfg_err = 0; busy_err = 0; rdy_err = 0; img_err = 0; iv_cnt = 0; done_cnt = 0;
        prev_acc = 0; prev_pix = '0; err_exp = 0; err_seen = 0;

        start = 1'b1;
        for (int k = 1; k <= done_k + 1 && k <= 4000; k++) begin
            @(posedge clk); #1;
            start = 1'b0; in_val = 1'b0; result_val = 1'b0;
            host_valid = 1'b0; host_addr = '0; host_data = '0;

            if (k <= 11)
                chk({tag, "_cfg"}, 64'({cfg_valid, cfg_addr, cfg_data}),
                    64'({1'b1, exp_a[k-1], exp_d[k-1]}));
            else if (cfg_valid || cfg_addr != 0 || cfg_data != 0)
                cfg_err++;
            if (busy !== (k <= done_k)) busy_err++;
            rdy_exp = (k >= 12) && (acc < fs);
            if (in_rdy !== rdy_exp) rdy_err++;
            if (image_val !== prev_acc || (prev_acc && image !== prev_pix)) img_err++;
            if (image_val) iv_cnt++;
            if (done) begin
                done_cnt++;
                if (seen_k < 0) begin seen_k = k; err_seen = err; end
            end

            prev_acc = 0;
            if (k < done_k) begin
                if (k == 3) start = 1'b1;
                if (busy_wr && k == 5) begin
                    host_valid = 1'b1; host_addr = 4'd0; host_data = 32'($urandom_range(200, 100));
                end
                if (rdy_exp) begin
                    in_val = ($urandom_range(99) < val_pct);
                    in_image = 16'($urandom);
                    if (in_val) begin
                        acc++; prev_acc = 1; prev_pix = in_image;
                        if (acc == fs) D = k + 1;
                    end
                    if (early && quota > 0 && $urandom_range(99) < res_pct) result_val = 1'b1;
                end else begin
                    in_val = 1'($urandom);
                    in_image = 16'($urandom);
                    if (D > 0 && k >= D && quota > 0 && $urandom_range(99) < res_pct)
                        result_val = 1'b1;
                end
                if (result_val) begin
                    quota--; nres++;
                    if (D > 0 && k >= D) last_dr = k;
                    if (nres == m_exp && R < 0) R = k;
                end
                if (D > 0 && k >= D && R >= 0)
                    done_k = k + 1;
`ifdef FILTER_SEQ_WATCHDOG_EN
                else if (D > 0 && k >= D && !result_val &&
                         k - ((last_dr > D) ? last_dr : D) == WDOG - 1) begin
                    done_k = k + 1; err_exp = 1;
                end
`endif
            end
        end
        in_val = 1'b0; result_val = 1'b0; start = 1'b0;

        chk({tag, "_done_at"}, 64'(seen_k), 64'(done_k));
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_err"}, 64'(err_seen), 64'(err_exp));
        chk({tag, "_busy_errs"}, 64'(busy_err), 64'd0);
        chk({tag, "_rdy_errs"}, 64'(rdy_err), 64'd0);
        chk({tag, "_image_errs"}, 64'(img_err), 64'd0);
        chk({tag, "_image_pulses"}, 64'(iv_cnt), 64'(fs));
        chk({tag, "_cfg_idle_errs"}, 64'(cfg_err), 64'd0);
    endtask

    task automatic reset_mid_frame();
        int n;
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        // Cycle 5 is the fourth kernel pulse.
        chk("rst_pre_pulse", 64'({cfg_valid, cfg_addr, cfg_data}), 64'({1'b1, 5'd2, 16'd0, m_k[3]}));
        rst = 1'b1;
        @(posedge clk); #1;
        chk_quiet_outputs("rst_mid");
        rst = 1'b0;
        clear_model();
        n = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (cfg_valid || busy) n++;
        end
        chk("rst_no_more_pulses", 64'(n), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        clear_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed frame: 4x2, taps 1..9, shift 2 head 0, 8 results.
        host_wr(4'd0, 32'd4);
        host_wr(4'd1, 32'd2);
        host_wr(4'd2, 32'h0000_0200);
        for (int i = 0; i < 9; i++) host_wr(4'(3 + i), 32'(i + 1));
        host_wr(4'd12, 32'd8);
        run_frame("basic", 100, 100, 8, 0, 0);

        // Random geometry, kernels, stalls and result timing.
        for (int f = 0; f < 4; f++) begin
            host_wr(4'd0, 32'($urandom_range(6, 1)));
            host_wr(4'd1, 32'($urandom_range(5, 1)));
            host_wr(4'd2, 32'($urandom));
            for (int i = 0; i < 9; i++) host_wr(4'(3 + i), 32'($urandom));
            host_wr(4'd12, 32'($urandom_range(10, 0)));
            host_wr(4'($urandom_range(15, 13)), 32'($urandom));
            run_frame($sformatf("rand%0d", f), 60, 40, int'(m_exp), 1, 0);
        end

        // Width written while busy must not reach the following frame.
        host_wr(4'd0, 32'd3);
        host_wr(4'd1, 32'd2);
        host_wr(4'd12, 32'd4);
        run_frame("busy_wr", 80, 50, 4, 1, 1);
        run_frame("after_busy_wr", 80, 50, 4, 1, 0);

        host_wr(4'd1, 32'd0);
        run_frame("zero_height", 100, 100, 0, 0, 0);

        host_wr(4'd1, 32'd2);
        host_wr(4'd12, 32'd0);
        run_frame("zero_expected", 70, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) host_wr(4'(3 + i), 32'(16'hA0 + i));
        reset_mid_frame();
        run_frame("post_reset", 100, 100, 0, 0, 0);

`ifdef FILTER_SEQ_WATCHDOG_EN
        host_wr(4'd0, 32'd4);
        host_wr(4'd1, 32'd2);
        host_wr(4'd12, 32'd8);
        run_frame("wdog", 100, 50, 5, 0, 0);
        run_frame("wdog_clear", 100, 100, 8, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
